// File: rtl/square_calculator.sv
// Iterative shift-add squarer: one partial product per cycle, IN_W cycles plus a
// result-latch cycle. Start/done/error handshake matches the square-root unit.
module square_calculator #(
    parameter int IN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IN_W-1:0]   in,
    output logic [2*IN_W-1:0] out,
    output logic              error,
    output logic              done,
    output logic              busy
);
    localparam int OUT_W = 2 * IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   acc, mcand;
    logic [IN_W-1:0]    mult;
    logic [CNT_W-1:0]   cnt;
    logic               accept, last_iter;

    // Start is only honoured when no calculation is in flight.
    assign accept    = start && (state == IDLE || state == DONE);
    assign last_iter = (cnt == CNT_W'(IN_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (accept)    state_nxt = CALC;
            CALC:       if (last_iter) state_nxt = FINISH;
            FINISH:                    state_nxt = DONE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            mult  <= '0;
            cnt   <= '0;
            out   <= '0;
            error <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        mcand <= OUT_W'(in);
                        mult  <= in;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        error <= 1'b0;
                    end
                end
                CALC: begin
                    if (mult[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mult  <= mult >> 1;
                    cnt   <= cnt + 1'b1;
                end
                FINISH: begin
                    // MSB set means "negative" to the square-root unit's input.
                    out   <= acc;
                    error <= acc[OUT_W-1];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/square_calculator.md
Name: square_calculator

Overview:
- Iterative shift-add squarer: takes an unsigned 8-bit root and produces its 16-bit square over IN_W cycles.
- Inverse companion of the square-root unit; used to regenerate and check radicands from computed roots.
- Uses the same start/done/error handshake as the square-root unit.
- error flags a result that does not fit the square-root unit's input convention, where bit 15 set means negative.

Parameters:
- IN_W, 8, root width in bits; output width is 2*IN_W.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only when the block is not busy.
- in  input  IN_W  unsigned root operand.
- out  output  2*IN_W  square result; valid while done=1.
- error  output  1  result MSB set (square >= 2^(2*IN_W-1)); valid while done=1.
- done  output  1  result valid; held until the next accepted start.
- busy  output  1  calculation in progress.

Behaviour:
- Reset is asynchronous and active-high; it can take effect mid-operation.
  - Outputs: out=0, error=0, done=0, busy=0.
  - Internal: state=IDLE, acc=0, mcand=0, mult=0, cnt=0.
  - Any calculation in flight is abandoned; no done pulse follows.
- Internal registers:
  - acc: 2*IN_W bits.
  - mcand: 2*IN_W bits, zero-extended copy of in.
  - mult: IN_W bits.
  - cnt: sized to count 0..IN_W.
- IDLE/DONE, start=1 at edge k:
  - mcand<=in, mult<=in, acc<=0, cnt<=0.
  - busy<=1, done<=0, error<=0; out keeps its old value.
  - Go to CALC.
- IDLE/DONE, start=0: hold all outputs. DONE is not exited without start.
- CALC, per edge:
  - If mult[0], acc<=acc+mcand; otherwise acc unchanged.
  - mcand<=mcand<<1; mult<=mult>>1; cnt<=cnt+1.
  - After the IN_W-th iteration (cnt==IN_W-1 at that edge), go to FINISH.
- FINISH, one edge:
  - out<=acc, error<=acc[2*IN_W-1].
  - done<=1, busy<=0; go to DONE.
- Latency: start sampled at edge k gives out/done/error valid after edge k+IN_W+1 (k+9 for the default).
- start while busy (CALC/FINISH) is ignored; the operands in flight are not disturbed.
- in is sampled only on the accepting edge; changes to in afterwards have no effect.
- Arithmetic:
  - Additions are 2*IN_W wide; the exact square never overflows 2*IN_W bits.
  - out always carries the true square, including when error=1.
- Back-to-back operation: start asserted on the edge after done rises is accepted. done drops on that edge, and the next result arrives IN_W+1 edges later.
- in=0: all iterations add nothing; out=0, error=0.

Test Plan:
- in=0, pulse start -> done=1 exactly 9 edges after the start edge; out=0, error=0, busy low with done.
- in=13 -> out=169, error=0. Then in=1 -> out=1; done deasserts on the accepting edge.
- in=181 -> out=32761 (0x7FF9), error=0. in=182 -> out=33124 (0x8164), error=1.
- in=255 -> out=65025 (0xFE01), error=1. The following start with in=2 -> out=4, error=0 (error cleared).
- in=100, start; at iteration 3 assert start with in=7 -> ignored; out=10000, latency unchanged.
- in=200, start; assert rst asynchronously mid-calculation -> out=0, done=0, busy=0, error=0 immediately. After release, in=12 -> out=144.
